// File: rtl/ddp_pkg.sv
// rtl/ddp_pkg.sv - shared DDP packet widths and buffer defaults
package ddp_pkg;

    // Packet word layout: 256-bit payload plus 11 control bits.
    localparam int DDP_PAYLOAD_W = 256;
    localparam int DDP_CTRL_W    = 11;
    localparam int DDP_PKT_W     = DDP_PAYLOAD_W + DDP_CTRL_W;

    // Default packet buffer geometry between assembly and cut stages.
    localparam int DDP_FIFO_DEPTH  = 16;
    localparam int DDP_FIFO_AF_LVL = 12;

    // Structured view of a packet word; the buffer itself treats it as opaque bits.
    typedef struct packed {
        logic [DDP_CTRL_W-1:0]    ctrl;
        logic [DDP_PAYLOAD_W-1:0] payload;
    } ddpPkt_t;

    // Width of an occupancy count able to hold 0..depth inclusive.
    function automatic int ddpLevelWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ddp_pkt_fifo_ram.sv
// rtl/ddp_pkt_fifo_ram.sv - simple dual-port packet storage with registered read
module ddp_pkt_fifo_ram
    import ddp_pkg::*;
#(
    parameter int DATA_W = DDP_PKT_W,
    parameter int DEPTH  = DDP_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    // Storage array is never cleared so it can map onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Synchronous read port; the output register holds its value between reads
    // and is the only part of the RAM that is reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/ddp_pkt_fifo.sv
// rtl/ddp_pkt_fifo.sv - DDP packet buffer between assembly and cut stages
module ddp_pkt_fifo
    import ddp_pkg::*;
#(
    parameter int DATA_W = DDP_PKT_W,
    parameter int DEPTH  = DDP_FIFO_DEPTH,
    parameter int AF_LVL = DDP_FIFO_AF_LVL,
    parameter int LVL_W  = ddpLevelWidth(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ddpPktPush,
    input  logic [DATA_W-1:0] ddpPktDataIn,
    output logic              ddpPktFull,
    output logic              ddpPktAFull,
    input  logic              ddpPktPop,
    output logic [DATA_W-1:0] ddpPktDataOut,
    output logic              ddpPktDataValid,
    output logic              ddpPktEmpty,
    output logic [LVL_W-1:0]  ddpPktLevel,
    output logic              ddpPktOvfErr,
    output logic              ddpPktUdfErr
);

    localparam int IDX_W = LVL_W - 1;

    // Pointers carry one extra wrap bit above the index so full and empty
    // are distinguishable when the indices coincide.
    logic [LVL_W-1:0] wrPtr;
    logic [LVL_W-1:0] rdPtr;
    logic [LVL_W-1:0] wrPtrNxt;
    logic [LVL_W-1:0] rdPtrNxt;
    logic [LVL_W-1:0] levelNxt;
    logic             pushOk;
    logic             popOk;
    logic             fullNxt;
    logic             emptyNxt;
    logic             aFullNxt;

    // Accept decisions use the registered flags, so a push while full or a pop
    // while empty is rejected even when the other side moves in the same cycle.
    always_comb begin
        pushOk = ddpPktPush && !ddpPktFull;
        popOk  = ddpPktPop && !ddpPktEmpty;
    end

    // Next pointer values and the flags derived from them; pointer arithmetic
    // wraps naturally modulo 2*DEPTH.
    always_comb begin
        wrPtrNxt = wrPtr + {{(LVL_W-1){1'b0}}, pushOk};
        rdPtrNxt = rdPtr + {{(LVL_W-1){1'b0}}, popOk};
        levelNxt = wrPtrNxt - rdPtrNxt;
        emptyNxt = (wrPtrNxt == rdPtrNxt);
        fullNxt  = (wrPtrNxt[IDX_W-1:0] == rdPtrNxt[IDX_W-1:0]) &&
                   (wrPtrNxt[IDX_W] != rdPtrNxt[IDX_W]);
        aFullNxt = (levelNxt >= LVL_W'(AF_LVL));
    end

    // Pointers and registered status flags update on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            ddpPktLevel <= '0;
            ddpPktEmpty <= 1'b1;
            ddpPktFull  <= 1'b0;
            ddpPktAFull <= 1'b0;
        end else begin
            wrPtr       <= wrPtrNxt;
            rdPtr       <= rdPtrNxt;
            ddpPktLevel <= levelNxt;
            ddpPktEmpty <= emptyNxt;
            ddpPktFull  <= fullNxt;
            ddpPktAFull <= aFullNxt;
        end
    end

    // Sticky misuse flags, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ddpPktOvfErr <= 1'b0;
            ddpPktUdfErr <= 1'b0;
        end else begin
            if (ddpPktPush && ddpPktFull) begin
                ddpPktOvfErr <= 1'b1;
            end
            if (ddpPktPop && ddpPktEmpty) begin
                ddpPktUdfErr <= 1'b1;
            end
        end
    end

    // Read-data valid pulses the cycle after an accepted pop, aligned with the
    // RAM's registered read output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ddpPktDataValid <= 1'b0;
        end else begin
            ddpPktDataValid <= popOk;
        end
    end

    ddp_pkt_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W)
    ) uRam (
        .clock  (clock),
        .reset  (reset),
        .wrEn   (pushOk),
        .wrAddr (wrPtr[IDX_W-1:0]),
        .wrData (ddpPktDataIn),
        .rdEn   (popOk),
        .rdAddr (rdPtr[IDX_W-1:0]),
        .rdData (ddpPktDataOut)
    );

endmodule

// File: tb/tb_ddp_pkt_fifo.sv
// tb/tb_ddp_pkt_fifo.sv - scoreboard bench for the DDP packet buffer
module tb_ddp_pkt_fifo;

    localparam int W      = 267;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 12;
    localparam int LVL_W  = 5;

    logic             clock;
    logic             reset;
    logic             ddpPktPush;
    logic [W-1:0]     ddpPktDataIn;
    logic             ddpPktFull;
    logic             ddpPktAFull;
    logic             ddpPktPop;
    logic [W-1:0]     ddpPktDataOut;
    logic             ddpPktDataValid;
    logic             ddpPktEmpty;
    logic [LVL_W-1:0] ddpPktLevel;
    logic             ddpPktOvfErr;
    logic             ddpPktUdfErr;

    ddp_pkt_fifo #(
        .DATA_W (W),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL),
        .LVL_W  (LVL_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ddpPktPush      (ddpPktPush),
        .ddpPktDataIn    (ddpPktDataIn),
        .ddpPktFull      (ddpPktFull),
        .ddpPktAFull     (ddpPktAFull),
        .ddpPktPop       (ddpPktPop),
        .ddpPktDataOut   (ddpPktDataOut),
        .ddpPktDataValid (ddpPktDataValid),
        .ddpPktEmpty     (ddpPktEmpty),
        .ddpPktLevel     (ddpPktLevel),
        .ddpPktOvfErr    (ddpPktOvfErr),
        .ddpPktUdfErr    (ddpPktUdfErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           checkCnt = 0;
    int           passCnt  = 0;
    logic [W-1:0] mdlQ[$];
    logic [W-1:0] expQ[$];
    logic [W-1:0] mdlLast = '0;
    logic         mdlOvf  = 1'b0;
    logic         mdlUdf  = 1'b0;

    task automatic checkVal(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checkCnt++;
        if (got === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mkWord();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r[W-1:0];
    endfunction

    task automatic checkFlags(input string ctx);
        int lvl;
        lvl = mdlQ.size();
        checkVal({ctx, ".level"}, W'(ddpPktLevel), W'(lvl));
        checkVal({ctx, ".empty"}, W'(ddpPktEmpty), W'(lvl == 0));
        checkVal({ctx, ".full"},  W'(ddpPktFull),  W'(lvl == DEPTH));
        checkVal({ctx, ".afull"}, W'(ddpPktAFull), W'(lvl >= AF_LVL));
        checkVal({ctx, ".ovf"},   W'(ddpPktOvfErr), W'(mdlOvf));
        checkVal({ctx, ".udf"},   W'(ddpPktUdfErr), W'(mdlUdf));
    endtask

    // One clock of stimulus; expected read words are queued as pops are driven
    // and consumed when the DUT raises DataValid.
    task automatic step(input logic push, input logic pop, input logic [W-1:0] data, input string ctx);
        logic         pushOk;
        logic         popOk;
        logic [W-1:0] exp;
        ddpPktPush   = push;
        ddpPktPop    = pop;
        ddpPktDataIn = data;
        pushOk = push && (mdlQ.size() < DEPTH);
        popOk  = pop && (mdlQ.size() > 0);
        if (push && !pushOk) mdlOvf = 1'b1;
        if (pop && !popOk) mdlUdf = 1'b1;
        if (popOk) expQ.push_back(mdlQ.pop_front());
        if (pushOk) mdlQ.push_back(data);
        @(posedge clock);
        #1;
        ddpPktPush = 1'b0;
        ddpPktPop  = 1'b0;
        checkVal({ctx, ".valid"}, W'(ddpPktDataValid), W'(popOk));
        if (ddpPktDataValid) begin
            checkVal({ctx, ".sbHasEntry"}, W'(expQ.size() != 0), W'(1));
            if (expQ.size() != 0) begin
                exp = expQ.pop_front();
                mdlLast = exp;
                checkVal({ctx, ".dataOut"}, ddpPktDataOut, exp);
            end
        end else begin
            checkVal({ctx, ".dataHold"}, ddpPktDataOut, mdlLast);
        end
        checkFlags(ctx);
    endtask

    task automatic modelReset();
        mdlQ.delete();
        expQ.delete();
        mdlLast = '0;
        mdlOvf  = 1'b0;
        mdlUdf  = 1'b0;
    endtask

    task automatic checkResetState(input string ctx);
        checkVal({ctx, ".valid"},   W'(ddpPktDataValid), W'(0));
        checkVal({ctx, ".dataOut"}, ddpPktDataOut, W'(0));
        checkFlags(ctx);
    endtask

    initial begin
        logic [W-1:0] w;
        reset        = 1'b0;
        ddpPktPush   = 1'b0;
        ddpPktPop    = 1'b0;
        ddpPktDataIn = '0;
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        checkResetState("rst");
        reset = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, "idle");

        // Small in-order transfer.
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, W'(i), "push3");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "pop3");
        step(1'b0, 1'b0, '0, "pop3idle");

        // Fill to full, overflow attempt, full push+pop, then drain.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, mkWord(), "fill");
        step(1'b1, 1'b0, mkWord(), "ovf");
        step(1'b1, 1'b1, mkWord(), "fullPushPop");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, "drain");
        step(1'b0, 1'b0, '0, "drainIdle");

        // Underflow, empty push+pop, then normal traffic still works.
        doResetQuick();
        step(1'b0, 1'b1, '0, "udf");
        step(1'b1, 1'b1, mkWord(), "emptyPushPop");
        step(1'b1, 1'b0, mkWord(), "postUdfPush");
        step(1'b0, 1'b1, '0, "postUdfPop");
        step(1'b0, 1'b1, '0, "postUdfPop2");
        step(1'b0, 1'b0, '0, "postUdfIdle");

        // Steady-state streaming at level 8 across several pointer wraps.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, mkWord(), "lvl8");
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, mkWord(), "stream");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, "streamDrain");
        step(1'b0, 1'b0, '0, "streamIdle");

        // Asynchronous reset in the middle of a cycle with content stored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, mkWord(), "fill5");
        step(1'b0, 1'b1, '0, "preRstPop");
        #3;
        reset = 1'b0;
        modelReset();
        #1;
        checkResetState("midRst");
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(1'b0, 1'b1, '0, "postRstPop");
        w = mkWord();
        step(1'b1, 1'b0, w, "postRstPush");
        step(1'b0, 1'b1, '0, "postRstPop2");
        step(1'b0, 1'b0, '0, "postRstIdle");

        checkVal("sbDrained", W'(expQ.size()), W'(0));
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    // Clears the sticky flags between scenarios so each one sees its own errors.
    task automatic doResetQuick();
        #3;
        reset = 1'b0;
        modelReset();
        @(posedge clock);
        #1;
        checkResetState("quickRst");
        reset = 1'b1;
    endtask

endmodule
